// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Imported by the fetch unit, its buffer and its bus interface.
package fetch_pkg;
    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;
    localparam int PC_INCR = 4;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
        logic               filled;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bus bundle of the fetch unit: redirect input, memory request/response, consumer output.
// master = fetch unit side, slave = memory / next-PC / decode side.
interface inst_fetch_unit_if;
    import fetch_pkg::*;

    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               mem_req_valid;
    logic [ADDR_W-1:0]  mem_req_addr;
    logic               mem_req_ready;
    logic               mem_rsp_valid;
    logic [INSTR_W-1:0] mem_rsp_data;
    logic               out_valid;
    logic [ADDR_W-1:0]  out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic               out_ready;

    modport master (
        input  redirect_valid, redirect_pc,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output out_valid, out_pc, out_instr,
        input  out_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  out_valid, out_pc, out_instr,
        output out_ready
    );
endinterface

// File: rtl/fetch_buffer.sv
// Circular {pc, instr, filled} buffer: allocate at tail, fill in allocation order, pop at head.
// Reports occupancy and the number of allocated-but-unfilled entries.
module fetch_buffer import fetch_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic               CLK,
    input  logic               resetl,
    input  logic               flush,
    input  logic               alloc,
    input  logic [ADDR_W-1:0]  alloc_pc,
    input  logic               fill,
    input  logic [INSTR_W-1:0] fill_instr,
    input  logic               pop,
    output logic [PTR_W:0]     count,
    output logic [PTR_W:0]     unfilled,
    output logic               head_valid,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [INSTR_W-1:0] head_instr
);
    logic [PTR_W-1:0] head_reg, tail_reg, fill_reg;
    logic [PTR_W:0]   count_reg, unfilled_reg;
    logic             alloc_ok, fill_ok, pop_ok;

    logic [DEPTH-1:0]              filled_vec;
    logic [DEPTH-1:0][ADDR_W-1:0]  pc_vec;
    logic [DEPTH-1:0][INSTR_W-1:0] instr_vec;

    // Stray responses (nothing outstanding) and pops of an unfilled head are dropped here.
    assign alloc_ok = alloc && (count_reg < (PTR_W+1)'(DEPTH));
    assign fill_ok  = fill && (unfilled_reg != '0);
    assign pop_ok   = pop && filled_vec[head_reg];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            fetch_entry_t entry_reg;

            always_ff @(posedge CLK) begin
                if (resetl) begin
                    entry_reg <= '0;
                end else if (flush) begin
                    entry_reg.filled <= 1'b0;
                end else begin
                    if (alloc_ok && tail_reg == PTR_W'(gi)) begin
                        entry_reg.pc     <= alloc_pc;
                        entry_reg.filled <= 1'b0;
                    end
                    if (fill_ok && fill_reg == PTR_W'(gi)) begin
                        entry_reg.instr  <= fill_instr;
                        entry_reg.filled <= 1'b1;
                    end
                    if (pop_ok && head_reg == PTR_W'(gi)) begin
                        entry_reg.filled <= 1'b0;
                    end
                end
            end

            assign filled_vec[gi] = entry_reg.filled;
            assign pc_vec[gi]     = entry_reg.pc;
            assign instr_vec[gi]  = entry_reg.instr;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (resetl || flush) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            fill_reg     <= '0;
            count_reg    <= '0;
            unfilled_reg <= '0;
        end else begin
            if (alloc_ok) tail_reg <= tail_reg + PTR_W'(1);
            if (fill_ok)  fill_reg <= fill_reg + PTR_W'(1);
            if (pop_ok)   head_reg <= head_reg + PTR_W'(1);
            count_reg    <= count_reg + {{PTR_W{1'b0}}, alloc_ok} - {{PTR_W{1'b0}}, pop_ok};
            unfilled_reg <= unfilled_reg + {{PTR_W{1'b0}}, alloc_ok} - {{PTR_W{1'b0}}, fill_ok};
        end
    end

    assign count      = count_reg;
    assign unfilled   = unfilled_reg;
    assign head_valid = filled_vec[head_reg];
    assign head_pc    = pc_vec[head_reg];
    assign head_instr = instr_vec[head_reg];
endmodule

// File: rtl/inst_fetch_unit.sv
// Decoupled fetch front end: sequential PC generation, in-order memory requests,
// buffered {pc, instr} delivery and redirect flush of in-flight responses.
module inst_fetch_unit import fetch_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic              CLK,
    input  logic              resetl,
    input  logic [ADDR_W-1:0] startpc,
    inst_fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);

    fetch_state_t       state_reg;
    logic [ADDR_W-1:0]  fetch_pc_reg;
    logic [PTR_W:0]     discard_reg;
    logic [PTR_W:0]     discard_base, discard_next;
    logic [PTR_W:0]     count, unfilled;
    logic               req_fire, fill, pop;
    logic               head_valid;
    logic [ADDR_W-1:0]  head_pc;
    logic [INSTR_W-1:0] head_instr;

    // Gated on the pre-edge count: a slot freed by a pop is only reusable next cycle.
    assign bus.mem_req_valid = (state_reg == FETCH) && (count < (PTR_W+1)'(DEPTH)) &&
                               !bus.redirect_valid && !resetl;
    assign bus.mem_req_addr  = fetch_pc_reg;
    assign req_fire          = bus.mem_req_valid && bus.mem_req_ready;
    assign fill              = bus.mem_rsp_valid && (state_reg == FETCH);
    assign pop               = bus.out_valid && bus.out_ready;

    assign bus.out_valid = head_valid && !resetl;
    assign bus.out_pc    = resetl ? '0 : head_pc;
    assign bus.out_instr = resetl ? '0 : head_instr;

    fetch_buffer #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_buffer (
        .CLK        (CLK),
        .resetl     (resetl),
        .flush      (bus.redirect_valid),
        .alloc      (req_fire),
        .alloc_pc   (fetch_pc_reg),
        .fill       (fill),
        .fill_instr (bus.mem_rsp_data),
        .pop        (pop),
        .count      (count),
        .unfilled   (unfilled),
        .head_valid (head_valid),
        .head_pc    (head_pc),
        .head_instr (head_instr)
    );

    // Responses still owed at a redirect; one arriving this very cycle is already accounted for.
    always_comb begin
        discard_base = (state_reg == FLUSH) ? discard_reg : unfilled;
        discard_next = discard_base;
        if (bus.mem_rsp_valid && discard_base != '0) begin
            discard_next = discard_base - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (resetl) begin
            state_reg    <= FETCH;
            fetch_pc_reg <= word_align(startpc);
            discard_reg  <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc_reg <= word_align(bus.redirect_pc);
            discard_reg  <= discard_next;
            state_reg    <= (discard_next != '0) ? FLUSH : FETCH;
        end else begin
            if (req_fire) begin
                fetch_pc_reg <= fetch_pc_reg + ADDR_W'(PC_INCR);
            end
            if (state_reg == FLUSH && bus.mem_rsp_valid) begin
                discard_reg <= discard_reg - (PTR_W+1)'(1);
                if (discard_reg == (PTR_W+1)'(1)) begin
                    state_reg <= FETCH;
                end
            end
        end
    end

    // A response with nothing outstanding is a memory-side protocol error.
    always_ff @(posedge CLK) begin
        if (!resetl && bus.mem_rsp_valid && state_reg == FETCH) begin
            assert (unfilled != '0);
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus a randomized run
// compared against a queue-based reference model of the fetch front end.
module tb_inst_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetl;
    logic [63:0] startpc;

    inst_fetch_unit_if bus ();

    inst_fetch_unit #(.DEPTH(DEPTH)) dut (
        .CLK     (clk),
        .resetl  (resetl),
        .startpc (startpc),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Memory model: responses in order, each after a (possibly random) latency.
    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];
    int    cyc      = 0;
    int    last_due = 0;
    int    lat_min  = 1;
    int    lat_max  = 1;

    // Reference model: pending (requested, not yet answered) PCs and ready {pc, instr} pairs.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;
    logic [63:0] m_pc;
    logic [63:0] m_pend[$];
    ent_t        m_rdy[$];
    int          m_disc = 0;

    logic [63:0] req_log[$];
    logic [63:0] out_log[$];

    // Advance one clock: sample at negedge, update model, then drive the memory after posedge.
    task automatic step();
        logic        hs_m, pop_m, rsp, hs_d, pop_d, rst_s;
        logic [31:0] data;
        logic [63:0] hs_addr;
        ent_t        e;
        int          lat, due;
        @(negedge clk);
        rst_s   = resetl;
        hs_m    = !resetl && m_disc == 0 && (m_pend.size() + m_rdy.size()) < DEPTH &&
                  !bus.redirect_valid && bus.mem_req_ready;
        pop_m   = !resetl && m_rdy.size() > 0 && bus.out_ready;
        hs_d    = bus.mem_req_valid && bus.mem_req_ready;
        hs_addr = bus.mem_req_addr;
        pop_d   = bus.out_valid && bus.out_ready;
        rsp     = bus.mem_rsp_valid;
        data    = bus.mem_rsp_data;
        if (hs_d) req_log.push_back(hs_addr);
        if (pop_d) begin
            out_log.push_back(bus.out_pc);
            $display("out pc=%h instr=%h", bus.out_pc, bus.out_instr);
        end

        if (rst_s) begin
            m_pc = {startpc[63:2], 2'b00};
            m_pend.delete();
            m_rdy.delete();
            m_disc = 0;
        end else if (bus.redirect_valid) begin
            m_disc = m_disc + m_pend.size() - (rsp ? 1 : 0);
            if (m_disc < 0) m_disc = 0;
            m_pend.delete();
            m_rdy.delete();
            m_pc = {bus.redirect_pc[63:2], 2'b00};
        end else begin
            if (pop_m) void'(m_rdy.pop_front());
            if (rsp) begin
                if (m_disc > 0) begin
                    m_disc--;
                end else if (m_pend.size() > 0) begin
                    e.pc    = m_pend.pop_front();
                    e.instr = data;
                    m_rdy.push_back(e);
                end
            end
            if (hs_m) begin
                m_pend.push_back(m_pc);
                m_pc = m_pc + 64'd4;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        if (rst_s) begin
            mq.delete();
            last_due          = cyc;
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = '0;
        end else begin
            if (hs_d) begin
                lat = $urandom_range(lat_max, lat_min);
                due = cyc + lat - 1;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mq.push_back('{hs_addr, due});
            end
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = mq[0].addr[31:0];
                void'(mq.pop_front());
            end else begin
                bus.mem_rsp_valid = 1'b0;
                bus.mem_rsp_data  = $urandom;
            end
        end
    endtask

    task automatic apply_reset(input logic [63:0] pc);
        resetl             = 1'b1;
        startpc            = pc;
        bus.redirect_valid = 1'b0;
        step();
        step();
        resetl = 1'b0;
        req_log.delete();
        out_log.delete();
        #1;
    endtask

    task automatic test_reset();
        resetl = 1'b1;
        startpc = 64'h1003;
        step();
        step();
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL reset_req_valid: got %b want 0", bus.mem_req_valid); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.out_pc !== 64'h0) begin n_errors++; $display("FAIL reset_out_pc: got %h want 0", bus.out_pc); end
        n_checks++; if (bus.out_instr !== 32'h0) begin n_errors++; $display("FAIL reset_out_instr: got %h want 0", bus.out_instr); end
        resetl = 1'b0;
        #1;
        n_checks++; if (bus.mem_req_valid !== 1'b1) begin n_errors++; $display("FAIL reset_release_valid: got %b want 1", bus.mem_req_valid); end
        n_checks++; if (bus.mem_req_addr !== 64'h1000) begin n_errors++; $display("FAIL reset_aligned_pc: got %h want 1000", bus.mem_req_addr); end
    endtask

    task automatic test_basic_stream();
        logic [63:0] exp_pc;
        lat_min = 1; lat_max = 1;
        bus.out_ready = 1'b1; bus.mem_req_ready = 1'b1;
        apply_reset(64'h1000);
        step();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_early_valid: got %b want 0", bus.out_valid); end
        step();
        n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL basic_latency: got %b want 1", bus.out_valid); end
        for (int k = 0; k < 8; k++) begin
            exp_pc = 64'h1000 + 64'(4 * k);
            n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc) begin n_errors++; $display("FAIL basic_pc[%0d]: got valid=%b pc=%h want pc=%h", k, bus.out_valid, bus.out_pc, exp_pc); end
            n_checks++; if (bus.out_instr !== exp_pc[31:0]) begin n_errors++; $display("FAIL basic_instr[%0d]: got %h want %h", k, bus.out_instr, exp_pc[31:0]); end
            step();
        end
    endtask

    task automatic test_backpressure();
        lat_min = 1; lat_max = 1;
        bus.out_ready = 1'b0; bus.mem_req_ready = 1'b1;
        apply_reset(64'h1000);
        repeat (10) step();
        n_checks++; if (req_log.size() != 4) begin n_errors++; $display("FAIL bp_req_count: got %0d want 4", req_log.size()); end
        for (int i = 0; i < 4 && i < req_log.size(); i++) begin
            n_checks++; if (req_log[i] !== 64'h1000 + 64'(4 * i)) begin n_errors++; $display("FAIL bp_req_addr[%0d]: got %h want %h", i, req_log[i], 64'h1000 + 64'(4 * i)); end
        end
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL bp_req_stall: got %b want 0", bus.mem_req_valid); end
        bus.out_ready = 1'b1;
        repeat (12) step();
        n_checks++; if (out_log.size() < 8) begin n_errors++; $display("FAIL bp_out_count: got %0d want >=8", out_log.size()); end
        for (int i = 0; i < 8 && i < out_log.size(); i++) begin
            n_checks++; if (out_log[i] !== 64'h1000 + 64'(4 * i)) begin n_errors++; $display("FAIL bp_out_pc[%0d]: got %h want %h", i, out_log[i], 64'h1000 + 64'(4 * i)); end
        end
    endtask

    task automatic test_redirect_flush();
        int waited;
        lat_min = 3; lat_max = 3;
        bus.out_ready = 1'b1; bus.mem_req_ready = 1'b1;
        apply_reset(64'h1000);
        step();
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h2002;
        #1;
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL redir_withdraw: got %b want 0", bus.mem_req_valid); end
        step();
        bus.redirect_valid = 1'b0;
        #1;
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL flush_enter: got %b want 0", bus.mem_req_valid); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_empty: got %b want 0", bus.out_valid); end
        step();
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL flush_hold: got %b want 0", bus.mem_req_valid); end
        step();
        n_checks++; if (bus.mem_req_valid !== 1'b1) begin n_errors++; $display("FAIL flush_exit: got %b want 1", bus.mem_req_valid); end
        n_checks++; if (bus.mem_req_addr !== 64'h2000) begin n_errors++; $display("FAIL flush_target: got %h want 2000", bus.mem_req_addr); end
        waited = 0;
        while (!bus.out_valid && waited < 10) begin step(); waited++; end
        n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL flush_out_timeout: got %b want 1", bus.out_valid); end
        n_checks++; if (bus.out_pc !== 64'h2000 || bus.out_instr !== 32'h2000) begin n_errors++; $display("FAIL flush_out_pc: got pc=%h instr=%h want 2000", bus.out_pc, bus.out_instr); end
    endtask

    task automatic test_wrap();
        logic [63:0] exp_w [4];
        exp_w[0] = 64'hFFFF_FFFF_FFFF_FFF8;
        exp_w[1] = 64'hFFFF_FFFF_FFFF_FFFC;
        exp_w[2] = 64'h0;
        exp_w[3] = 64'h4;
        lat_min = 1; lat_max = 1;
        bus.out_ready = 1'b1; bus.mem_req_ready = 1'b1;
        apply_reset(64'hFFFF_FFFF_FFFF_FFF8);
        repeat (8) step();
        n_checks++; if (out_log.size() < 4) begin n_errors++; $display("FAIL wrap_count: got %0d want >=4", out_log.size()); end
        for (int i = 0; i < 4 && i < out_log.size(); i++) begin
            n_checks++; if (out_log[i] !== exp_w[i]) begin n_errors++; $display("FAIL wrap_pc[%0d]: got %h want %h", i, out_log[i], exp_w[i]); end
        end
    endtask

    task automatic test_simultaneous();
        lat_min = 1; lat_max = 1;
        bus.out_ready = 1'b1; bus.mem_req_ready = 1'b1;
        apply_reset(64'h1000);
        repeat (5) step();
        n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL simul_pre_valid: got %b want 1", bus.out_valid); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h3000;
        step();
        bus.redirect_valid = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL simul_empty: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.mem_req_valid !== 1'b1) begin n_errors++; $display("FAIL simul_no_flush: got %b want 1", bus.mem_req_valid); end
        n_checks++; if (bus.mem_req_addr !== 64'h3000) begin n_errors++; $display("FAIL simul_target: got %h want 3000", bus.mem_req_addr); end
        step();
        step();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h3000) begin n_errors++; $display("FAIL simul_out_pc: got valid=%b pc=%h want 3000", bus.out_valid, bus.out_pc); end
    endtask

    task automatic test_reset_midstream();
        lat_min = 1; lat_max = 1;
        bus.out_ready = 1'b1; bus.mem_req_ready = 1'b1;
        apply_reset(64'h1000);
        repeat (6) step();
        resetl  = 1'b1;
        startpc = 64'h40;
        step();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_req_valid: got %b want 0", bus.mem_req_valid); end
        n_checks++; if (bus.out_pc !== 64'h0) begin n_errors++; $display("FAIL midrst_out_pc: got %h want 0", bus.out_pc); end
        resetl = 1'b0;
        req_log.delete();
        #1;
        n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 64'h40) begin n_errors++; $display("FAIL midrst_first_req: got valid=%b addr=%h want 40", bus.mem_req_valid, bus.mem_req_addr); end
        step();
        n_checks++; if (req_log.size() == 0 || req_log[0] !== 64'h40) begin n_errors++; $display("FAIL midrst_req_log: got %0d reqs want first 40", req_log.size()); end
    endtask

    task automatic test_random();
        logic exp_rv, exp_ov;
        lat_min = 1; lat_max = 4;
        bus.out_ready = 1'b1; bus.mem_req_ready = 1'b1;
        apply_reset({$urandom, $urandom});
        for (int i = 0; i < 800; i++) begin
            bus.out_ready      = ($urandom_range(9, 0) < 7);
            bus.mem_req_ready  = ($urandom_range(9, 0) < 7);
            bus.redirect_valid = ($urandom_range(19, 0) == 0);
            bus.redirect_pc    = {$urandom, $urandom};
            #1;
            exp_rv = (m_disc == 0) && ((m_pend.size() + m_rdy.size()) < DEPTH) && !bus.redirect_valid;
            exp_ov = (m_rdy.size() > 0);
            n_checks++; if (bus.mem_req_valid !== exp_rv) begin n_errors++; $display("FAIL rand_req_valid@%0d: got %b want %b", i, bus.mem_req_valid, exp_rv); end
            if (exp_rv) begin
                n_checks++; if (bus.mem_req_addr !== m_pc) begin n_errors++; $display("FAIL rand_req_addr@%0d: got %h want %h", i, bus.mem_req_addr, m_pc); end
            end
            n_checks++; if (bus.out_valid !== exp_ov) begin n_errors++; $display("FAIL rand_out_valid@%0d: got %b want %b", i, bus.out_valid, exp_ov); end
            if (exp_ov) begin
                n_checks++; if (bus.out_pc !== m_rdy[0].pc || bus.out_instr !== m_rdy[0].instr) begin n_errors++; $display("FAIL rand_out@%0d: got pc=%h instr=%h want pc=%h instr=%h", i, bus.out_pc, bus.out_instr, m_rdy[0].pc, m_rdy[0].instr); end
            end
            step();
        end
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        resetl             = 1'b1;
        startpc            = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.mem_req_ready  = 1'b1;
        bus.mem_rsp_valid  = 1'b0;
        bus.mem_rsp_data   = '0;
        bus.out_ready      = 1'b1;
        test_reset();
        test_basic_stream();
        test_backpressure();
        test_redirect_flush();
        test_wrap();
        test_simultaneous();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Decoupled instruction-fetch front end for the 64-bit ARMv8-subset core; sits directly upstream of decode and register read.
- Generates sequential fetch PCs, issues in-order valid/ready requests to instruction memory, and buffers up to DEPTH {pc, instr} pairs.
- Delivers {pc, instr} to the consumer over valid/ready.
- Accepts branch/CBZ redirects from next-PC logic and flushes wrong-path work, including responses still in flight.

Parameters:
- DEPTH, 4, buffer entries and maximum outstanding requests; power of two, ≥2
- PTR_W, $clog2(DEPTH), pointer width (derived)

Ports:
- CLK  input  1  clock; all state updates on posedge
- resetl  input  1  reset, synchronous, active-high
- startpc  input  64  PC loaded while resetl=1
- redirect_valid  input  1  branch taken; flush and refetch
- redirect_pc  input  64  redirect target; bits [1:0] forced to 0
- mem_req_valid  output  1  fetch request
- mem_req_addr  output  64  fetch address (word aligned)
- mem_req_ready  input  1  memory accepts request
- mem_rsp_valid  input  1  response; in order; no backpressure
- mem_rsp_data  input  32  instruction word
- out_valid  output  1  head entry filled
- out_pc  output  64  PC of head entry
- out_instr  output  32  instruction at head
- out_ready  input  1  consumer takes head

Behaviour:
- Reset (resetl=1 at posedge):
  - fetch_pc <= {startpc[63:2],2'b00}
  - all entries freed; head/tail pointers, count and discard counter zeroed
  - state <= FETCH
  - while resetl=1: mem_req_valid=0, out_valid=0, out_pc=0, out_instr=0
- Reset mid-operation drops all in-flight responses silently. The memory side is reset together with this block.
- Buffer model:
  - A circular buffer of DEPTH entries with fields {pc, instr, filled}.
  - An entry is allocated at the tail when a request handshakes.
  - It is filled in allocation order by responses, tracked by a fill pointer.
  - It is popped at the head when out_valid && out_ready.
- FSM states:
  - FETCH: normal operation.
  - FLUSH: discard counter > 0. No requests are issued; each mem_rsp_valid decrements the counter; move to FETCH when the counter reaches 0.
- Request issue:
  - mem_req_valid = state==FETCH && count<DEPTH && !redirect_valid && !resetl
  - mem_req_addr = fetch_pc
  - On handshake: allocate entry {pc=fetch_pc, filled=0}, count++, fetch_pc += 4.
  - fetch_pc wraps modulo 2^64.
- Withdrawal: mem_req_valid may drop without ready only on a redirect; the memory side must tolerate this.
- Response (in FETCH): write mem_rsp_data into the entry at the fill pointer, set filled=1, advance the fill pointer.
- Output:
  - out_valid = head entry filled; out_pc/out_instr are driven from head registers.
  - A response written at edge N is visible at out_valid after edge N. Minimum request-to-output latency is 2 cycles with 1-cycle memory.
  - Throughput is 1 instruction/cycle once memory returns 1 response/cycle.
- Redirect (redirect_valid=1 at posedge, resetl=0):
  - fetch_pc <= {redirect_pc[63:2],2'b00}
  - all entries freed; count <= 0
  - discard <= (allocated-but-unfilled entries) − (mem_rsp_valid this cycle ? 1 : 0)
  - state <= FLUSH if discard>0, else FETCH
- Simultaneous events:
  - Redirect and pop in the same cycle: redirect wins; the pop is harmless.
  - Redirect during FLUSH: retarget fetch_pc; the discard counter continues counting from its current value (no new requests were issued).
  - Push and pop in the same cycle at count==DEPTH: the pop frees a slot, but the request is gated on the pre-edge count. No same-cycle refill, by design.
- Protocol errors: a response with no outstanding request is ignored. A simulation assertion fires.

Decomposition:
- Shared package fetch_pkg:
  - state enum {FETCH, FLUSH}
  - INSTR_W=32, ADDR_W=64, PC_INCR=4
  - typedef fetch_entry_t {pc[63:0], instr[31:0], filled}
- One sub-module, fetch_buffer:
  - circular buffer with tail/fill/head pointers, count, flush
  - reports unfilled-entry count for discard computation
- Parent inst_fetch_unit holds the FSM, fetch_pc, discard counter and request gating.

Test Plan:
- Basic stream (1-cycle memory, data=addr[31:0]; reset with startpc=0x1000, then release; out_ready=1):
  - out_pc sequence 0x1000, 0x1004, 0x1008…, one per cycle.
  - First out_valid 2 cycles after the first handshake.
- Backpressure (out_ready=0):
  - Exactly 4 requests (0x1000–0x100C) issued, then mem_req_valid=0.
  - Raise out_ready: outputs 0x1000… in order; no PC skipped or duplicated.
- Redirect with 2 responses in flight (3-cycle memory, redirect_pc=0x2002):
  - Enters FLUSH; 2 responses are dropped.
  - Next request addr=0x2000; next out_pc=0x2000.
- Wrap-around (startpc=0xFFFFFFFFFFFFFFF8):
  - Output PCs ...FFF8, ...FFFC, 0x0, 0x4.
- Simultaneous events:
  - Redirect in the same cycle as an out handshake and a mem response: buffer empty next cycle, discard reflects the response; first post-redirect out_pc equals the target.
  - Assert resetl mid-stream with startpc=0x40: out_valid=0 the next cycle; first request after release is 0x40.
